// File: rtl/pq_access_arbiter.sv
// pq_access_arbiter
//
// Shares one priority queue among NUM_REQ requesters. Each accepted request
// becomes a single queue operation: one ISSUE cycle that drives the queue
// strobes, a one-cycle response pulse, then SETTLE_CYCLES idle cycles so the
// queue can finish its internal compare-swap before the next operation.
//
// Handshake: a requester raises i_req_valid with stable op/data and holds them
// until it sees its o_req_ready bit high in the same cycle (valid && ready is
// the accept). o_req_ready is combinational, one-hot, and only ever high in
// IDLE. Responses are an unconditional one-cycle o_rsp_valid pulse (no
// back-pressure).
//
// Ports
//   i_CLK, i_RSTn     clock (rising edge), asynchronous active-low reset
//   i_req_valid       per-requester request valid
//   i_req_op          per-requester op, 2 bits each: 01 enq, 10 deq, 11 replace
//   i_req_data        per-requester data, DATA_WIDTH bits each
//   o_req_ready       one-hot accept strobe
//   o_rsp_valid/id/data/err   response pulse, the cycle after ISSUE
//   o_pq_wrt/read/data        queue strobes and write data (ISSUE only)
//   i_pq_full/empty/data      queue status and current root
//   o_busy            high whenever the FSM is not IDLE
//   o_state           current FSM state (debug visibility)

module pq_access_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 4,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_CLK,
    input  logic                          i_RSTn,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [2*NUM_REQ-1:0]          i_req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_rsp_valid,
    output logic [ID_W-1:0]               o_rsp_id,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_err,
    output logic                          o_pq_wrt,
    output logic                          o_pq_read,
    output logic [DATA_WIDTH-1:0]         o_pq_data,
    input  logic                          i_pq_full,
    input  logic                          i_pq_empty,
    input  logic [DATA_WIDTH-1:0]         i_pq_data,
    output logic                          o_busy,
    output logic [1:0]                    o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t                  state_q;
    logic [ID_W-1:0]         last_grant_q;
    logic [ID_W-1:0]         id_q;
    logic [1:0]              op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [3:0]              cnt_q;
    logic                    rsp_valid_q;
    logic [ID_W-1:0]         rsp_id_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_err_q;

    // Unpacked views of the flat request buses, so the grant mux indexes arrays.
    logic [1:0]            req_op_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_op_arr[k]   = i_req_op[2*k +: 2];
        assign req_data_arr[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting just after the last granted requester.
    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       cand;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic [1:0]            grant_op;
    logic [DATA_WIDTH-1:0] grant_data;

    always_comb begin
        grant_found  = 1'b0;
        grant_idx    = '0;
        cand         = '0;
        grant_onehot = '0;
        grant_op     = 2'b00;
        grant_data   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_grant_q) + off) % NUM_REQ);
            if (!grant_found && i_req_valid[cand]) begin
                grant_found        = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
                grant_op           = req_op_arr[cand];
                grant_data         = req_data_arr[cand];
            end
        end
    end

    // Ready is forced low while reset is held so the outputs are all zero
    // even if requesters keep their valid bits up through reset.
    assign o_req_ready = (state_q == ST_IDLE && i_RSTn) ? grant_onehot : '0;

    // Legality is judged against the live queue status during ISSUE.
    // A zero enqueue is refused because zero marks an empty queue slot.
    logic op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            2'b01:   op_legal = !i_pq_full && (data_q != '0);
            2'b10:   op_legal = !i_pq_empty;
            2'b11:   op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    logic                  issue_go;
    logic [DATA_WIDTH-1:0] rsp_data_sel;

    assign issue_go = (state_q == ST_ISSUE) && op_legal;

    // op bit 0 maps to the write strobe and bit 1 to the read strobe, which
    // gives enq=wrt, deq=read, replace=both directly from the encoding.
    assign o_pq_wrt  = issue_go && op_q[0];
    assign o_pq_read = issue_go && op_q[1];
    assign o_pq_data = issue_go ? data_q : '0;

    // Dequeue/replace report the root as it was before the queue updates.
    always_comb begin
        rsp_data_sel = '0;
        if (op_legal) begin
            rsp_data_sel = op_q[1] ? i_pq_data : data_q;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            op_q         <= 2'b00;
            data_q       <= '0;
            cnt_q        <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // Response fields are only non-zero during the one-cycle pulse.
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        last_grant_q <= grant_idx;
                        id_q         <= grant_idx;
                        op_q         <= grant_op;
                        data_q       <= grant_data;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_data_q  <= rsp_data_sel;
                    rsp_err_q   <= !op_legal;
                    if (op_legal) begin
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= ST_SETTLE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    // Counts SETTLE_LOAD down to zero: SETTLE_CYCLES cycles total.
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_state     = state_q;

endmodule

// File: tb/tb_pq_access_arbiter.sv
// Testbench for pq_access_arbiter: a behavioural priority-queue environment,
// a request-level reference model feeding expected-response and
// expected-strobe queues, and a negedge monitor that pops and compares.

module tb_pq_access_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int S   = 4;
    localparam int IDW = 2;
    localparam int CAP = 4;
    localparam int EW  = 32 + IDW + 1 + W;
    localparam int SW  = 32 + 2 + W;

    logic           i_CLK = 1'b0;
    logic           i_RSTn = 1'b0;
    logic [N-1:0]   i_req_valid = '0;
    logic [2*N-1:0] i_req_op = '0;
    logic [N*W-1:0] i_req_data = '0;
    logic [N-1:0]   o_req_ready;
    logic           o_rsp_valid;
    logic [IDW-1:0] o_rsp_id;
    logic [W-1:0]   o_rsp_data;
    logic           o_rsp_err;
    logic           o_pq_wrt;
    logic           o_pq_read;
    logic [W-1:0]   o_pq_data;
    logic           i_pq_full = 1'b0;
    logic           i_pq_empty = 1'b1;
    logic [W-1:0]   i_pq_data = '0;
    logic           o_busy;
    logic [1:0]     o_state;

    pq_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn),
        .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty), .i_pq_data(i_pq_data),
        .o_busy(o_busy), .o_state(o_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc++;

    // ---------------- shared state ----------------
    int checks = 0;
    int errors = 0;

    logic [W-1:0] pq[$];          // behavioural queue contents (unordered)
    logic [EW-1:0] exp_q[$];      // {rsp_cycle, id, err, data}
    logic [SW-1:0] stb_q[$];      // {strobe_cycle, wrt, read, data}

    int ref_last  = N - 1;
    int next_free = 0;
    int last_acc  = -100;
    int acc_cnt [N];
    int wait_ops[N];
    int grant_log[$];
    int acc_cyc_log[$];

    // monitor -> environment strobe hand-off (counter handshake)
    int           stb_cnt = 0;
    int           stb_done = 0;
    logic         pend_wr = 1'b0;
    logic         pend_rd = 1'b0;
    logic [W-1:0] pend_data = '0;

    // initial -> environment preload hand-off
    int           load_req = 0;
    int           load_done = 0;
    int           pre_n = 0;
    logic [W-1:0] pre[CAP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int pq_max_idx();
        int m = 0;
        for (int i = 1; i < pq.size(); i++) if (pq[i] > pq[m]) m = i;
        return m;
    endfunction

    function automatic logic [W-1:0] pq_root();
        if (pq.size() == 0) return '0;
        return pq[pq_max_idx()];
    endfunction

    // ---------------- priority-queue environment ----------------
    always @(posedge i_CLK) begin
        #1;
        if (load_req != load_done) begin
            pq.delete();
            for (int i = 0; i < pre_n; i++) pq.push_back(pre[i]);
            load_done = load_req;
        end
        if (stb_cnt != stb_done) begin
            stb_done = stb_cnt;
            if (pend_rd && pq.size() != 0) pq.delete(pq_max_idx());
            if (pend_wr && pend_data != '0 && pq.size() < CAP) pq.push_back(pend_data);
        end
        i_pq_full  = (pq.size() >= CAP);
        i_pq_empty = (pq.size() == 0);
        i_pq_data  = pq_root();
    end

    // ---------------- monitor / reference model ----------------
    always @(negedge i_CLK) begin
        logic [N-1:0]  acc;
        logic [EW-1:0] e;
        logic [SW-1:0] s;
        logic [1:0]    op;
        logic [W-1:0]  d;
        logic [W-1:0]  rd;
        logic          err;
        int            k;
        int            g;
        int            c;
        if (!i_RSTn) begin
            check("reset_outputs",
                  {o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_err, o_rsp_data,
                   o_pq_wrt, o_pq_read, o_pq_data, o_busy}, 64'd0);
            exp_q.delete();
            stb_q.delete();
            ref_last  = N - 1;
            next_free = 0;
            last_acc  = -100;
            for (int i = 0; i < N; i++) wait_ops[i] = 0;
        end else begin
            check("busy", o_busy, (cyc > last_acc) && (cyc < next_free));

            if (o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {o_rsp_id, o_rsp_err, o_rsp_data}, 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", {32'(cyc), o_rsp_id, o_rsp_err, o_rsp_data}, e);
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
                e = exp_q.pop_front();
                check("rsp_missing", {32'(cyc), o_rsp_valid}, {e[EW-1 -: 32], 1'b1});
            end

            if (o_pq_wrt || o_pq_read) begin
                pend_wr   = o_pq_wrt;
                pend_rd   = o_pq_read;
                pend_data = o_pq_data;
                stb_cnt++;
                if (stb_q.size() == 0) begin
                    check("strobe_unexpected", {o_pq_wrt, o_pq_read, o_pq_data}, 64'd0);
                end else begin
                    s = stb_q.pop_front();
                    check("strobe", {32'(cyc), o_pq_wrt, o_pq_read, o_pq_data}, s);
                end
            end else if (stb_q.size() != 0 && int'(stb_q[0][SW-1 -: 32]) <= cyc) begin
                s = stb_q.pop_front();
                check("strobe_missing", {32'(cyc), 2'b00}, {s[SW-1 -: 32], s[W+1 -: 2]});
            end

            check("ready_legal",
                  $onehot0(o_req_ready) && ((o_req_ready & ~i_req_valid) == '0) &&
                  (o_req_ready == '0 || cyc >= next_free), 1);
            if (cyc >= next_free && i_req_valid != '0)
                check("no_stall", (o_req_ready != '0), 1);

            acc = o_req_ready & i_req_valid;
            if (acc != '0) begin
                k = 0;
                for (int i = 0; i < N; i++) if (acc[i]) k = i;
                g = -1;
                for (int off = 1; off <= N; off++) begin
                    c = (ref_last + off) % N;
                    if (g < 0 && i_req_valid[c]) g = c;
                end
                check("grant", k, g);

                op = i_req_op[2*k +: 2];
                d  = i_req_data[k*W +: W];
                case (op)
                    2'b01:   begin err = (pq.size() >= CAP) || (d == '0); rd = err ? '0 : d; end
                    2'b10:   begin err = (pq.size() == 0); rd = err ? '0 : pq_root(); end
                    2'b11:   begin err = 1'b0; rd = pq_root(); end
                    default: begin err = 1'b1; rd = '0; end
                endcase
                exp_q.push_back({32'(cyc + 2), IDW'(k), err, rd});
                if (!err) stb_q.push_back({32'(cyc + 1), op[0], op[1], d});

                check("fair", (wait_ops[k] <= N - 1), 1);
                for (int i = 0; i < N; i++) begin
                    if (i == k) wait_ops[i] = 0;
                    else if (i_req_valid[i]) wait_ops[i]++;
                end

                ref_last  = g;
                last_acc  = cyc;
                next_free = cyc + 2 + (err ? 0 : S);
                acc_cnt[k]++;
                grant_log.push_back(k);
                acc_cyc_log.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [1:0] op, input logic [W-1:0] d);
        i_req_valid[k]       = v;
        i_req_op[2*k +: 2]   = op;
        i_req_data[k*W +: W] = d;
    endtask

    task automatic wait_accept(input int k);
        int start;
        int n;
        start = acc_cnt[k];
        n = 0;
        while (acc_cnt[k] == start && n < 100) begin
            tick();
            n++;
        end
        check("accept_timeout", (n < 100), 1);
        set_req(k, 1'b0, 2'b00, '0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((o_busy || exp_q.size() != 0 || stb_q.size() != 0) && n < 100);
        check("idle_timeout", (n < 100), 1);
    endtask

    task automatic load_pq(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
        pre[0] = a; pre[1] = b; pre[2] = c; pre[3] = d;
        pre_n = n;
        load_req++;
        tick();
        tick();
    endtask

    function automatic int log_at(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return -1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < acc_cyc_log.size()) return acc_cyc_log[i];
        return -1000;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        int seen[N];
        int r;
        logic [1:0] rop;
        for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; wait_ops[i] = 0; end

        i_RSTn = 1'b0;
        repeat (3) tick();
        i_RSTn = 1'b1;

        // Enqueue 0x0005 from requester 2 into an empty queue.
        base = grant_log.size();
        set_req(2, 1'b1, 2'b01, 16'h0005);
        wait_accept(2);
        wait_idle();
        check("t1_grant", log_at(base), 2);
        check("t1_queue", pq.size(), 1);

        // Dequeue from requester 1 with root 0x0009.
        load_pq(1, 16'h0009, 0, 0, 0);
        set_req(1, 1'b1, 2'b10, 16'h0000);
        wait_accept(1);
        wait_idle();
        check("t2_queue_empty", pq.size(), 0);

        // Enqueue while full is refused; the next requester is taken at T+2.
        load_pq(4, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        base = grant_log.size();
        set_req(0, 1'b1, 2'b01, 16'h0003);
        set_req(1, 1'b1, 2'b11, 16'h0007);
        wait_accept(0);
        wait_accept(1);
        wait_idle();
        check("t3_order", {log_at(base), log_at(base + 1)}, {32'd0, 32'd1});
        check("t3_gap", cyc_at(base + 1) - cyc_at(base), 2);

        // Zero enqueue and dequeue-while-empty are both refused.
        load_pq(0, 0, 0, 0, 0);
        set_req(3, 1'b1, 2'b01, 16'h0000);
        set_req(2, 1'b1, 2'b10, 16'h0000);
        wait_accept(2);
        wait_accept(3);
        wait_idle();
        check("t4_queue_untouched", pq.size(), 0);

        // All requesters valid continuously out of reset.
        i_RSTn = 1'b0;
        tick();
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 2'b11, W'(k + 1));
        tick();
        base = grant_log.size();
        i_RSTn = 1'b1;
        n = 0;
        while (grant_log.size() < base + 5 && n < 200) begin tick(); n++; end
        check("t5_timeout", (n < 200), 1);
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 2'b00, '0);
        wait_idle();
        for (int i = 0; i < 5; i++) check("t5_rr_order", log_at(base + i), i % N);

        // Reset during SETTLE aborts; requester 0 wins right after release.
        load_pq(0, 0, 0, 0, 0);
        set_req(0, 1'b1, 2'b01, 16'h0007);
        wait_accept(0);
        tick();
        tick();
        #2;
        i_RSTn = 1'b0;
        #1;
        check("t6_async_zero",
              {o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data, o_pq_wrt, o_pq_read,
               o_pq_data, o_busy}, 64'd0);
        set_req(0, 1'b1, 2'b01, 16'h0008);
        tick();
        tick();
        i_RSTn = 1'b1;
        @(negedge i_CLK);
        check("t6_first_grant", o_req_ready, 4'b0001);
        tick();
        set_req(0, 1'b0, 2'b00, '0);
        wait_idle();

        // Randomized traffic.
        for (int k = 0; k < N; k++) seen[k] = acc_cnt[k];
        repeat (1500) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (acc_cnt[k] != seen[k]) begin
                    seen[k] = acc_cnt[k];
                    i_req_valid[k] = 1'b0;
                end
                if (!i_req_valid[k] && $urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 15);
                    rop = (r == 0) ? 2'b00 : (r <= 6) ? 2'b01 : (r <= 11) ? 2'b10 : 2'b11;
                    set_req(k, 1'b1, rop,
                            ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom_range(1, 16'hFFFF)));
                end
            end
        end
        n = 0;
        while (i_req_valid != '0 && n < 200) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (acc_cnt[k] != seen[k]) begin
                    seen[k] = acc_cnt[k];
                    i_req_valid[k] = 1'b0;
                end
            end
            n++;
        end
        check("drain_timeout", (n < 200), 1);
        wait_idle();
        check("drain_queues", exp_q.size() + stb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
